// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the cache controller (master) and the backing data memory (slave).
interface data_memory_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              busy;

    modport master (output read, write, address, writedata, input readdata, busy);
    modport slave  (input read, write, address, writedata, output readdata, busy);
endinterface

// File: rtl/data_memory_ctrl.sv
// Fixed-latency word memory behind the cache: IDLE -> ACCESS (LATENCY cycles) -> DONE.
// Optional access counters (rd_count/wr_count) are built when MEM_ACCESS_CNT_EN is defined.
module data_memory_ctrl #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 5
) (
    input  logic clock,
    input  logic reset_n,
    data_memory_ctrl_if.slave bus
`ifdef MEM_ACCESS_CNT_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e            state_q;
    logic [7:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              commit;

    // Busy rises in the same cycle as the request so the cache stalls immediately.
    assign bus.busy     = (state_q == ACCESS) || ((state_q == IDLE) && (bus.read || bus.write));
    assign bus.readdata = rdata_q;
    assign commit       = (state_q == ACCESS) && (cnt_q == 8'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            mem_q   <= '{default: '0};
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.read || bus.write) begin
                        addr_q  <= bus.address;
                        wdata_q <= bus.writedata;
                        wr_q    <= bus.write;
                        cnt_q   <= CNT_INIT;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!commit) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        if (wr_q) mem_q[addr_q] <= wdata_q;
                        else      rdata_q       <= mem_q[addr_q];
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MEM_ACCESS_CNT_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    // Counters saturate rather than wrap so a long run never reads back as low traffic.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else if (commit) begin
            if (wr_q && wr_cnt_q != 16'hFFFF)  wr_cnt_q <= wr_cnt_q + 16'd1;
            if (!wr_q && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: stimulus queues expected (readdata, busy length) per access; monitor checks on each busy fall.
module tb_data_memory_ctrl;
    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 32;
    localparam int LATENCY = 5;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        int                cycles;
        string             name;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    data_memory_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MEM_ACCESS_CNT_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    data_memory_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
`ifdef MEM_ACCESS_CNT_EN
        ,
        .rd_count(rd_count),
        .wr_count(wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    // One access: request asserted after an edge, held for the whole busy window, dropped in DONE.
    task automatic access(input string name, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] exp_rd, input bit hold);
        exp_t e;
        e.rdata = exp_rd; e.cycles = LATENCY + 1; e.name = name;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = wd;
        repeat (LATENCY + 1) @(posedge clk);
        #1;
        if (hold) @(negedge clk);
        bus.read = 1'b0; bus.write = 1'b0;
    endtask

    // Monitor: counts busy-high cycles and compares on every busy fall.
    initial begin
        int   bcnt = 0;
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.busy) begin
                bcnt++;
            end else if (prev) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_access got busy_len=%0d exp=no access", bcnt);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_rdata"}, bus.readdata, e.rdata);
                    check({e.name, "_busylen"}, DATA_W'(bcnt), DATA_W'(e.cycles));
                end
                bcnt = 0;
            end
            prev = bus.busy;
        end
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.writedata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", DATA_W'(bus.busy), '0);
        check("reset_rdata", bus.readdata, '0);
        rst_n = 1'b1;

        access("rd0_after_reset", 1, 0, 6'd0,  32'h0,        32'h0,        0);
        access("wr1",             0, 1, 6'd1,  32'hDEADBEEF, 32'h0,        0);
        access("rd1",             1, 0, 6'd1,  32'h0,        32'hDEADBEEF, 0);
        access("rd1_held",        1, 0, 6'd1,  32'h0,        32'hDEADBEEF, 1);
        access("rw2",             1, 1, 6'd2,  32'hCAFEBABE, 32'hDEADBEEF, 0);
        access("rd2",             1, 0, 6'd2,  32'h0,        32'hCAFEBABE, 0);
        access("wr63",            0, 1, 6'd63, 32'hA5A5A5A5, 32'hCAFEBABE, 0);
        access("wr0",             0, 1, 6'd0,  32'h11111111, 32'hCAFEBABE, 0);
        access("rd63",            1, 0, 6'd63, 32'h0,        32'hA5A5A5A5, 0);
        access("rd0",             1, 0, 6'd0,  32'h0,        32'h11111111, 0);

        // Write to 63 aborted by reset in the second ACCESS cycle: busy drops after 2 high cycles.
        e.rdata = '0; e.cycles = 2; e.name = "abort_wr63";
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.write = 1'b1; bus.address = 6'd63; bus.writedata = 32'h12345678;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0; bus.write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        access("rd63_after_abort", 1, 0, 6'd63, 32'h0, 32'h0, 0);
        access("rd1_after_reset",  1, 0, 6'd1,  32'h0, 32'h0, 0);

        repeat (4) @(posedge clk);
        #1;
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL pending_accesses got=%0d exp=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
